// File: rtl/sdaccel_buffer_pkg.sv
// Shared definitions for the SDAccel SELF/AXI stream buffers.
//
// Purpose:
//   Holds the constants and helpers shared by both buffer directions:
//   - default parameter values;
//   - FIFO depth, count width and pointer width derived from the index size;
//   - the SELF transfer predicate (a token moves when valid is high and stop is low).
//
// Ports: none (package).
package sdaccel_buffer_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH      = 32'd16;
  localparam int unsigned DEFAULT_FIFO_INDEX_SIZE = 32'd2;

  // Number of FIFO entries for a given index size.
  function automatic int unsigned buffer_depth(input int unsigned index_size);
    return 32'd1 << index_size;
  endfunction

  // The occupancy count must represent 0..depth inclusive, hence one extra bit.
  function automatic int unsigned count_width(input int unsigned index_size);
    return index_size + 32'd1;
  endfunction

  // Pointers wrap naturally at the depth, so they are exactly index_size bits.
  function automatic int unsigned ptr_width(input int unsigned index_size);
    return index_size;
  endfunction

  // SELF handshake: a token transfers when the producer is valid and the consumer is not stopping.
  function automatic logic self_transfer(input logic valid, input logic stop);
    return valid & ~stop;
  endfunction

endpackage

// File: rtl/axi_input_buffer_mem.sv
// Register-file store for the AXI input buffer.
//
// Purpose:
//   One synchronous write port and one asynchronous read port. Contents are
//   intentionally not reset; the owner only reads entries it has written.
//
// Ports:
//   clk   - clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (combinational from the stored registers)
module axi_input_buffer_mem
  import sdaccel_buffer_pkg::*;
#(
  parameter int unsigned DataWidth = DEFAULT_DATA_WIDTH,
  parameter int unsigned IndexSize = DEFAULT_FIFO_INDEX_SIZE
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [IndexSize-1:0] waddr,
  input  logic [DataWidth-1:0] wdata,
  input  logic [IndexSize-1:0] raddr,
  output logic [DataWidth-1:0] rdata
);

  localparam int unsigned DEPTH = buffer_depth(IndexSize);

  logic [DataWidth-1:0] storage_r [DEPTH];

  // Write port: store one entry per enabled cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      storage_r[waddr] <= wdata;
    end else begin
      storage_r[waddr] <= storage_r[waddr];
    end
  end

  assign rdata = storage_r[raddr];

endmodule

// File: rtl/axi_input_buffer.sv
// AXI-stream to SELF input buffer.
//
// Purpose:
//   Accepts beats on an AXI valid/ready interface and presents them in order on a
//   SELF valid/stop interface. A small register FIFO decouples the two sides and
//   breaks every combinational path between them: axiReady and dataOutValid are
//   registers, and dataOut is read from registered storage at a registered pointer.
//
// Configuration:
//   AXI_INPUT_BUFFER_FILL_LEVEL_EN - when defined, adds output fillLevel carrying
//   the registered occupancy count. When undefined the count stays internal.
//
// Ports:
//   clk          - single clock
//   srst         - synchronous active-high reset
//   axiValid     - AXI beat present on axiDataIn
//   axiDataIn    - AXI beat data
//   axiReady     - buffer accepts a beat this cycle
//   dataOutValid - SELF token valid on dataOut
//   dataOut      - SELF token data
//   dataOutStop  - SELF consumer stall; token held while high
//   fillLevel    - (optional) occupancy count 0..Depth
module axi_input_buffer
  import sdaccel_buffer_pkg::*;
#(
  parameter int unsigned DataWidth     = DEFAULT_DATA_WIDTH,
  parameter int unsigned FifoIndexSize = DEFAULT_FIFO_INDEX_SIZE
) (
  input  logic                 clk,
  input  logic                 srst,
  input  logic                 axiValid,
  input  logic [DataWidth-1:0] axiDataIn,
  output logic                 axiReady,
  output logic                 dataOutValid,
  output logic [DataWidth-1:0] dataOut,
`ifdef AXI_INPUT_BUFFER_FILL_LEVEL_EN
  input  logic                 dataOutStop,
  output logic [FifoIndexSize:0] fillLevel
`else
  input  logic                 dataOutStop
`endif
);

  localparam int unsigned DEPTH = buffer_depth(FifoIndexSize);
  localparam int unsigned CW    = count_width(FifoIndexSize);
  localparam int unsigned PW    = ptr_width(FifoIndexSize);

  localparam logic [CW-1:0] DEPTH_C     = CW'(DEPTH);
  localparam logic [CW-1:0] COUNT_ONE_C = CW'(1);
  localparam logic [CW-1:0] COUNT_ZERO  = CW'(0);
  localparam logic [PW-1:0] PTR_ONE_C   = PW'(1);

  logic [CW-1:0] count_r;
  logic [CW-1:0] count_next;
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic          ready_r;
  logic          valid_r;
  logic          push;
  logic          pop;

  // Handshakes only use registered flags, so no input reaches an output combinationally.
  assign push = axiValid & ready_r;
  assign pop  = self_transfer(valid_r, dataOutStop);

  // Next occupancy: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_next = count_r;
    case ({push, pop})
      2'b10:   count_next = count_r + COUNT_ONE_C;
      2'b01:   count_next = count_r - COUNT_ONE_C;
      default: count_next = count_r;
    endcase
  end

  // Pointer, count and flag state. The flags are registered from the next count, so
  // a pop while full raises axiReady only after the popping edge.
  always_ff @(posedge clk) begin
    if (srst) begin
      count_r  <= COUNT_ZERO;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      ready_r  <= 1'b0;
      valid_r  <= 1'b0;
    end else begin
      count_r  <= count_next;
      rd_ptr_r <= pop  ? rd_ptr_r + PTR_ONE_C : rd_ptr_r;
      wr_ptr_r <= push ? wr_ptr_r + PTR_ONE_C : wr_ptr_r;
      ready_r  <= (count_next != DEPTH_C);
      valid_r  <= (count_next != COUNT_ZERO);
    end
  end

  // Storage writes are suppressed during reset so no partial push lands.
  axi_input_buffer_mem #(
    .DataWidth (DataWidth),
    .IndexSize (FifoIndexSize)
  ) u_mem (
    .clk   (clk),
    .we    (push & ~srst),
    .waddr (wr_ptr_r),
    .wdata (axiDataIn),
    .raddr (rd_ptr_r),
    .rdata (dataOut)
  );

  assign axiReady     = ready_r;
  assign dataOutValid = valid_r;

`ifdef AXI_INPUT_BUFFER_FILL_LEVEL_EN
  assign fillLevel = count_r;
`else
  // Count remains internal; no extra port.
`endif

endmodule
